// File: rtl/rv_core_pkg.sv
// Shared types and constants for the RV32ICMFA fetch front end.
package rv_core_pkg;

   localparam int CORE_XLEN = 32;

   localparam logic [CORE_XLEN-1:0] INC_C            = 32'd2;
   localparam logic [CORE_XLEN-1:0] INC_I            = 32'd4;
   localparam logic [CORE_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // Redirect targets are forced to halfword alignment; bit0 is reported separately.
   function automatic logic [CORE_XLEN-1:0] align_pc(input logic [CORE_XLEN-1:0] addr);
      return {addr[CORE_XLEN-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect select: trap over branch over jump.
module pc_redirect_arb
   import rv_core_pkg::*;
#(
   parameter int XLEN = CORE_XLEN
) (
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            br_valid,
   input  logic [XLEN-1:0] br_pc,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_pc,
   output logic            redirect_valid,
   output logic [XLEN-1:0] tgt
);

   // Priority select of the redirect target
   always_comb begin
      redirect_valid = 1'b0;
      tgt            = {XLEN{1'b0}};
      if (trap_valid) begin
         redirect_valid = 1'b1;
         tgt            = trap_pc;
      end else if (br_valid) begin
         redirect_valid = 1'b1;
         tgt            = br_pc;
      end else if (jump_valid) begin
         redirect_valid = 1'b1;
         tgt            = jump_pc;
      end else begin
         redirect_valid = 1'b0;
         tgt            = {XLEN{1'b0}};
      end
   end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: redirects, +2/+4 stepping, stall and halt/wake.
// Optional REDIRECT_CNT_EN adds a saturating count of flush cycles.
module fetch_pc_ctrl
   import rv_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          XLEN     = CORE_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_in,
   output logic            if_req_valid,
   input  logic            if_req_ready,
   input  logic            if_is_c,
   output logic [XLEN-1:0] if_pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            br_valid,
   input  logic [XLEN-1:0] br_pc,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_pc,
   input  logic            halt_req,
   input  logic            wake,
   output logic            flush,
   output logic            misalign_err,
   output logic            halted
`ifdef REDIRECT_CNT_EN
   ,
   output logic [31:0]     redirect_cnt
`endif
);

   fetch_state_e    state;
   fetch_state_e    state_n;
   logic [XLEN-1:0] pc_n;
   logic            flush_n;
   logic            misalign_n;
   logic            redirect_valid;
   logic [XLEN-1:0] tgt;
   logic            accept;
   logic [XLEN-1:0] inc;

   pc_redirect_arb #(
      .XLEN (XLEN)
   ) u_arb (
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .br_valid       (br_valid),
      .br_pc          (br_pc),
      .jump_valid     (jump_valid),
      .jump_pc        (jump_pc),
      .redirect_valid (redirect_valid),
      .tgt            (tgt)
   );

   assign if_req_valid = (state == RUN) && !stall_in;
   assign accept       = if_req_valid && if_req_ready;
   assign inc          = if_is_c ? INC_C : INC_I;
   assign halted       = (state == HALT);

   // Next-state, next-PC and pulse generation
   always_comb begin
      state_n    = state;
      pc_n       = if_pc;
      flush_n    = 1'b0;
      misalign_n = 1'b0;
      case (state)
         BOOT: begin
            state_n = RUN;
         end
         RUN: begin
            // A redirect squashes any same-cycle accept and drops halt_req.
            if (redirect_valid) begin
               pc_n       = align_pc(tgt);
               flush_n    = 1'b1;
               misalign_n = tgt[0];
               state_n    = RUN;
            end else begin
               if (accept) begin
                  pc_n = if_pc + inc;
               end else begin
                  pc_n = if_pc;
               end
               if (halt_req) begin
                  state_n = HALT;
               end else begin
                  state_n = RUN;
               end
            end
         end
         HALT: begin
            // Only a trap can redirect out of HALT; branch/jump are ignored.
            if (trap_valid) begin
               pc_n       = align_pc(trap_pc);
               flush_n    = 1'b1;
               misalign_n = trap_pc[0];
               state_n    = RUN;
            end else if (wake) begin
               state_n = RUN;
            end else begin
               state_n = HALT;
            end
         end
         default: begin
            state_n = BOOT;
         end
      endcase
   end

   // State, PC and pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= BOOT;
         if_pc        <= RESET_PC;
         flush        <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         state        <= state_n;
         if_pc        <= pc_n;
         flush        <= flush_n;
         misalign_err <= misalign_n;
      end
   end

`ifdef REDIRECT_CNT_EN
   // Saturating count of cycles with flush asserted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         redirect_cnt <= 32'd0;
      end else if (flush && (redirect_cnt != 32'hFFFF_FFFF)) begin
         redirect_cnt <= redirect_cnt + 32'd1;
      end else begin
         redirect_cnt <= redirect_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed self-checking bench for fetch_pc_ctrl with an expected-value scoreboard.
module tb_fetch_pc_ctrl;

   logic        clk;
   logic        reset;
   logic        stall_in;
   logic        if_req_valid;
   logic        if_req_ready;
   logic        if_is_c;
   logic [31:0] if_pc;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic        br_valid;
   logic [31:0] br_pc;
   logic        jump_valid;
   logic [31:0] jump_pc;
   logic        halt_req;
   logic        wake;
   logic        flush;
   logic        misalign_err;
   logic        halted;
`ifdef REDIRECT_CNT_EN
   logic [31:0] redirect_cnt;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] pc;
      logic        fl;
      logic        mi;
      logic        ha;
      string       tag;
   } exp_t;

   exp_t sb[$];

   fetch_pc_ctrl #(
      .RESET_PC (32'h0000_0000),
      .XLEN     (32)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall_in     (stall_in),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_is_c      (if_is_c),
      .if_pc        (if_pc),
      .trap_valid   (trap_valid),
      .trap_pc      (trap_pc),
      .br_valid     (br_valid),
      .br_pc        (br_pc),
      .jump_valid   (jump_valid),
      .jump_pc      (jump_pc),
      .halt_req     (halt_req),
      .wake         (wake),
      .flush        (flush),
      .misalign_err (misalign_err),
      .halted       (halted)
`ifdef REDIRECT_CNT_EN
      ,
      .redirect_cnt (redirect_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Push the expectation, advance one clock, then pop and compare away from the edge.
   task automatic cyc(input logic [31:0] pc, input logic fl, input logic mi,
                      input logic ha, input string tag);
      exp_t e;
      exp_t g;
      e.pc = pc; e.fl = fl; e.mi = mi; e.ha = ha; e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk({g.tag, ".pc"},     if_pc,               g.pc);
      chk({g.tag, ".flush"},  32'(flush),          32'(g.fl));
      chk({g.tag, ".mis"},    32'(misalign_err),   32'(g.mi));
      chk({g.tag, ".halted"}, 32'(halted),         32'(g.ha));
   endtask

   task automatic clr;
      trap_valid = 1'b0; br_valid = 1'b0; jump_valid = 1'b0;
      halt_req   = 1'b0; wake     = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall_in = 1'b0; if_req_ready = 1'b0; if_is_c = 1'b0;
      trap_pc = 32'd0; br_pc = 32'd0; jump_pc = 32'd0;
      clr();
      @(posedge clk);
      #1;
      chk("rst.pc", if_pc, 32'h0000_0000);
      chk("rst.flush", 32'(flush), 32'd0);
      chk("rst.mis", 32'(misalign_err), 32'd0);
      chk("rst.halted", 32'(halted), 32'd0);
      chk("rst.req", 32'(if_req_valid), 32'd0);

      // Boot cycle issues no request, then sequential +4
      reset = 1'b0; if_req_ready = 1'b1;
      chk("boot.req", 32'(if_req_valid), 32'd0);
      cyc(32'h0, 1'b0, 1'b0, 1'b0, "boot_run");
      chk("run.req", 32'(if_req_valid), 32'd1);
      cyc(32'h4, 1'b0, 1'b0, 1'b0, "seq1");
      cyc(32'h8, 1'b0, 1'b0, 1'b0, "seq2");
      cyc(32'hC, 1'b0, 1'b0, 1'b0, "seq3");

      // Compressed/full alternation from 0x100
      jump_valid = 1'b1; jump_pc = 32'h100;
      cyc(32'h100, 1'b1, 1'b0, 1'b0, "jmp100");
      clr(); if_is_c = 1'b1;
      cyc(32'h102, 1'b0, 1'b0, 1'b0, "c1");
      if_is_c = 1'b0;
      cyc(32'h106, 1'b0, 1'b0, 1'b0, "i1");
      if_is_c = 1'b1;
      cyc(32'h108, 1'b0, 1'b0, 1'b0, "c2");
      if_is_c = 1'b0;

      // All three redirects at once: trap wins
      trap_valid = 1'b1; trap_pc = 32'h80;
      br_valid   = 1'b1; br_pc   = 32'h200;
      jump_valid = 1'b1; jump_pc = 32'h300;
      cyc(32'h80, 1'b1, 1'b0, 1'b0, "prio");
      clr();
      cyc(32'h84, 1'b0, 1'b0, 1'b0, "prio_after");
      br_valid = 1'b1; br_pc = 32'h200; jump_valid = 1'b1; jump_pc = 32'h300;
      cyc(32'h200, 1'b1, 1'b0, 1'b0, "br_over_jmp");
      clr();

      // Misaligned branch under stall, then hold while stalled
      stall_in = 1'b1; br_valid = 1'b1; br_pc = 32'h201;
      cyc(32'h200, 1'b1, 1'b1, 1'b0, "mis_br");
      clr();
      chk("stall.req", 32'(if_req_valid), 32'd0);
      cyc(32'h200, 1'b0, 1'b0, 1'b0, "stall_hold1");
      cyc(32'h200, 1'b0, 1'b0, 1'b0, "stall_hold2");
      stall_in = 1'b0;

      // Back-to-back redirects
      jump_valid = 1'b1; jump_pc = 32'h50;
      cyc(32'h50, 1'b1, 1'b0, 1'b0, "b2b_1");
      clr(); br_valid = 1'b1; br_pc = 32'h61;
      cyc(32'h60, 1'b1, 1'b1, 1'b0, "b2b_2");
      clr();

      // Halt at 0x40 with accept, jump ignored, wake resumes at 0x44
      jump_valid = 1'b1; jump_pc = 32'h40;
      cyc(32'h40, 1'b1, 1'b0, 1'b0, "to40");
      clr(); halt_req = 1'b1;
      cyc(32'h44, 1'b0, 1'b0, 1'b1, "halt");
      clr();
      chk("halt.req", 32'(if_req_valid), 32'd0);
      jump_valid = 1'b1; jump_pc = 32'h300; br_valid = 1'b1; br_pc = 32'h400;
      cyc(32'h44, 1'b0, 1'b0, 1'b1, "halt_ignore");
      clr(); wake = 1'b1;
      cyc(32'h44, 1'b0, 1'b0, 1'b0, "wake");
      clr();
      chk("wake.req", 32'(if_req_valid), 32'd1);
      cyc(32'h48, 1'b0, 1'b0, 1'b0, "resume");
      halt_req = 1'b1;
      cyc(32'h4C, 1'b0, 1'b0, 1'b1, "halt2");
      clr(); trap_valid = 1'b1; trap_pc = 32'h10; wake = 1'b1;
      cyc(32'h10, 1'b1, 1'b0, 1'b0, "halt_trap");
      clr(); if_req_ready = 1'b0;
      cyc(32'h10, 1'b0, 1'b0, 1'b0, "no_accept_hold");
      if_req_ready = 1'b1;

      // Redirect drops a same-cycle halt request
      jump_valid = 1'b1; jump_pc = 32'h20; halt_req = 1'b1;
      cyc(32'h20, 1'b1, 1'b0, 1'b0, "halt_dropped");
      clr();
      cyc(32'h24, 1'b0, 1'b0, 1'b0, "after_drop");

      // Wrap at the top of the address space
      jump_valid = 1'b1; jump_pc = 32'hFFFF_FFFC;
      cyc(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, "to_top");
      clr();
      cyc(32'h0, 1'b0, 1'b0, 1'b0, "wrap");

      // Asynchronous reset while a redirect pulse is in flight
      jump_valid = 1'b1; jump_pc = 32'hFFFF_FFFC;
      cyc(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, "pre_rst");
      clr(); br_valid = 1'b1; br_pc = 32'h44;
      #2;
      reset = 1'b1;
      #1;
      chk("arst.pc", if_pc, 32'h0000_0000);
      chk("arst.flush", 32'(flush), 32'd0);
      chk("arst.mis", 32'(misalign_err), 32'd0);
      chk("arst.req", 32'(if_req_valid), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0; clr();
      chk("reboot.req", 32'(if_req_valid), 32'd0);
      cyc(32'h0, 1'b0, 1'b0, 1'b0, "reboot_run");
      cyc(32'h4, 1'b0, 1'b0, 1'b0, "reboot_seq");

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
Sequences the fetch program counter for the RV32ICMFA core. Arbitrates between trap, branch and jump redirect sources and the sequential +2/+4 increment. Applies hazard stalls and halts/wakes fetch. Sits between the hazard/commit logic and the instruction-fetch port, and issues a one-cycle flush whenever the PC is redirected.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
XLEN, 32, address width; only 32 is supported

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
stall_in  in  1  hazard stall; suppresses fetch requests
if_req_valid  out  1  fetch request valid
if_req_ready  in  1  fetch port accepts request this cycle
if_is_c  in  1  accepted instruction is 16-bit; valid with accept
if_pc  out  XLEN  fetch address (registered)
trap_valid  in  1  trap/interrupt redirect request
trap_pc  in  XLEN  trap target
br_valid  in  1  taken branch / JALR redirect from EX
br_pc  in  XLEN  branch target
jump_valid  in  1  JAL redirect from ID
jump_pc  in  XLEN  JAL target
halt_req  in  1  WFI/EBREAK halt request from commit
wake  in  1  resume from halt
flush  out  1  squash in-flight fetch/decode (registered pulse)
misalign_err  out  1  redirect target had bit0 set (registered pulse)
halted  out  1  controller is in HALT

Behaviour:
- Reset (asynchronous, any time, including mid-redirect):
  - if_pc=RESET_PC; flush=0; misalign_err=0; state=BOOT.
  - if_req_valid=0, halted=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT → RUN after exactly one clock; no requests are issued in BOOT.
- if_req_valid = (state==RUN) && !stall_in. This is combinational and has no dependency on if_req_ready.
- Accept = if_req_valid && if_req_ready.
- Redirect priority: trap > br > jump. Selected target is tgt.
- RUN, cycle t, any redirect valid:
  - At t+1: if_pc = {tgt[31:1],1'b0} and flush=1.
  - misalign_err=1 at t+1 iff tgt[0]=1.
  - The redirect overrides stall_in, accept and halt_req. A request accepted at t is squashed by the flush and does not advance the PC.
  - halt_req in the same cycle is dropped.
- RUN, no redirect, accept at t: if_pc at t+1 = if_pc + (if_is_c ? 2 : 4), wrapping mod 2^32 (32'hFFFF_FFFC+4 = 0).
- RUN, no redirect, no accept: if_pc holds, including while stalled.
- RUN, halt_req, no redirect: enter HALT at t+1.
  - The PC advances if the request was accepted at t.
  - No flush is issued.
- HALT:
  - if_req_valid=0, halted=1, if_pc holds.
  - trap_valid → RUN with the trap redirect (same rules: flush, alignment).
  - Otherwise wake → RUN at t+1 with no flush.
  - br_valid and jump_valid are ignored.
  - trap and wake in the same cycle: the trap wins.
- flush and misalign_err are single-cycle pulses. Back-to-back redirects produce consecutive pulses, each with its own target.
- No redirect is buffered: redirect valids are single-cycle requests, and any valid not selected by priority is discarded.

Optional Feature:
REDIRECT_CNT_EN
- Defined:
  - Adds output redirect_cnt (32 bits), reset to 0.
  - Increments by 1 on every cycle that flush is asserted, saturating at 32'hFFFF_FFFF.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package rv_core_pkg:
  - FSM state enum (BOOT, RUN, HALT).
  - XLEN constant.
  - Instruction-length increment constants (INC_C=2, INC_I=4).
  - Default RESET_PC constant.
- One natural sub-module, pc_redirect_arb: the combinational 3-way priority select producing redirect_valid and tgt.

Test Plan:
- Reset release then ready=1, if_is_c=0 for 3 accepts → if_pc sequence 0, 4, 8, 0xC; if_req_valid=0 in the first cycle after reset.
- Alternating if_is_c=1,0,1 from 0x100 with ready=1 → if_pc 0x100, 0x102, 0x106, 0x108.
- trap_pc=0x80, br_pc=0x200 and jump_pc=0x300 all valid in one cycle → next if_pc=0x80, flush=1 for one cycle, misalign_err=0.
- br_pc=0x201 with stall_in=1 → if_pc=0x200, flush=1, misalign_err=1; if_pc then holds while stalled.
- halt_req at if_pc=0x40 with accept and is_c=0 → halted=1, if_pc=0x44 held; jump_valid ignored; wake → fetch resumes at 0x44. Repeat the halt and assert trap (trap_pc=0x10) while halted → if_pc=0x10, flush=1.
- reset asserted mid-redirect at if_pc=0xFFFF_FFFC → immediately if_pc=RESET_PC, flush=0. Separately, if_pc=0xFFFF_FFFC with accept and is_c=0 → if_pc=0 (wrap).
